uart_text_cmd_decoder: RTL and testbench
========================================

Name: uart_text_cmd_decoder

Overview:
Converts the UART receive byte stream into character-cell writes for the text-mode VGA frame buffer. Each command is three bytes in order: column, row, ASCII code. Columns, rows and buffer dimensions are parameters, so one block serves any text resolution. Adds over the fixed 80x30 path: range checking, inter-byte timeout resync, ready/valid backpressure toward the buffer, and error reporting. Sits between the UART receiver and the text buffer write port inside top.

Parameters:
COLS, 80, text columns per row
ROWS, 30, text rows
CHAR_W, 8, character code width in bits
ADDR_W, 12, buffer address width; must satisfy 2**ADDR_W >= COLS*ROWS
TIMEOUT, 4340, clk cycles allowed between bytes of one command (2 byte times at 115200 baud, 25 MHz clk)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
rx_valid  in  1  one-cycle pulse: rx_data holds a new byte
rx_data  in  8  received byte
wr_valid  out  1  write request to text buffer
wr_ready  in  1  buffer accepts write when wr_valid && wr_ready
wr_addr  out  ADDR_W  row*COLS + col
wr_data  out  CHAR_W  character code
busy  out  1  high in any state other than IDLE
err_range  out  1  one-cycle pulse: command dropped because col>=COLS or row>=ROWS
err_timeout  out  1  one-cycle pulse: partial command abandoned
err_overrun  out  1  one-cycle pulse: byte arrived while a write was pending and was dropped

Behaviour:
- Reset (resetn low at a clk edge): state IDLE, every output 0, timer 0, latched col/row cleared. Reset mid-command discards the partial command and causes no write.
- States: IDLE -> GET_ROW -> GET_CHAR -> WRITE -> IDLE, plus CLEAR (optional feature only).
- IDLE: on rx_valid, latch col = rx_data and go to GET_ROW.
- GET_ROW: on rx_valid, latch row and go to GET_CHAR.
- GET_CHAR: on rx_valid:
  - If col<COLS and row<ROWS: register wr_addr = row*COLS+col (no truncation; compute in ADDR_W bits) and wr_data = rx_data[CHAR_W-1:0]. Go to WRITE.
  - Otherwise: pulse err_range on the next cycle and go to IDLE.
- Latency: third byte's rx_valid in cycle N gives wr_valid high in cycle N+1.
- WRITE:
  - wr_valid, wr_addr and wr_data stay stable until a cycle in which wr_ready=1. wr_valid drops the following cycle and state returns to IDLE.
  - rx_valid in the same cycle as the handshake: byte is taken as the next column and state goes to GET_ROW.
  - rx_valid while wr_ready=0: byte dropped, err_overrun pulses next cycle, state unchanged.
- Timeout: timer clears on every accepted byte and counts in GET_ROW and GET_CHAR. When it reaches TIMEOUT-1 without rx_valid: go to IDLE and pulse err_timeout. If rx_valid arrives in that same cycle, the byte wins and there is no timeout.
- Error pulses last exactly one cycle each and are mutually independent.

Optional Feature:
Macro UART_TEXT_CLEAR_EN.
- Defined: in IDLE, rx_data==8'hFF enters CLEAR. CLEAR issues writes of 8'h20 (space) to addresses 0..COLS*ROWS-1 in ascending order, one per handshake, with the same stable-until-ready rule. After the last handshake it returns to IDLE. Bytes arriving during CLEAR are dropped with err_overrun. The timer is inactive in CLEAR.
- Undefined: 8'hFF is an ordinary column byte; it fails the range check, producing err_range after the char byte. The CLEAR state and its counter logic are absent.

Decomposition:
- Package vga_text_pkg:
  - default COLS/ROWS
  - ASCII_SPACE = 8'h20
  - CMD_CLEAR = 8'hFF
  - state enum
  - function computing cell address from row/col
- One sub-module: uart_gap_timer (load/clear, enable, terminal-count pulse, width clog2(TIMEOUT)).

Test Plan:
- Bytes 17, 29, 50 with wr_ready=1 -> one write: wr_addr=2337, wr_data=8'h32, wr_valid high exactly 1 cycle, starting 1 cycle after third rx_valid.
- Bytes 79, 0, 57 -> wr_addr=79, wr_data=8'h39. Then bytes 80, 0, 65 -> err_range pulse, no wr_valid.
- Byte 17 then TIMEOUT idle cycles -> err_timeout pulse, busy=0. Then bytes 5, 1, 120 -> wr_addr=85, wr_data=8'h78.
- wr_ready held low 20 cycles after a valid command, with one byte injected -> err_overrun pulse, wr_addr/wr_data unchanged. Release wr_ready -> single write.
- resetn low for 1 cycle after bytes 17, 29 -> all outputs 0. Subsequent bytes 3, 2, 65 -> wr_addr=163.
- With UART_TEXT_CLEAR_EN: byte 8'hFF, wr_ready=1 -> 2400 writes of 8'h20, addresses 0..2399 in order, then busy=0. Without the macro: bytes 255, 0, 65 -> err_range.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared types and constants for the UART text-command decoder.
// The CLEAR state exists only when UART_TEXT_CLEAR_EN is defined.
package vga_text_pkg;

    localparam int unsigned DEF_COLS = 80;
    localparam int unsigned DEF_ROWS = 30;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] CMD_CLEAR   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ROW,
        ST_GET_CHAR,
`ifdef UART_TEXT_CLEAR_EN
        ST_WRITE,
        ST_CLEAR
`else
        ST_WRITE
`endif
    } state_t;

    // Linear cell index of (row, col) in a row-major text buffer.
    function automatic int unsigned cell_addr(input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/uart_text_cmd_decoder_if.sv
// Byte-stream input and buffer-write output bundle of the text-command decoder.
// master = decoder side, slave = UART receiver / text buffer side.
interface uart_text_cmd_decoder_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned CHAR_W = 8
);

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [CHAR_W-1:0] wr_data;
    logic              busy;
    logic              err_range;
    logic              err_timeout;
    logic              err_overrun;

    modport master (
        input  rx_valid, rx_data, wr_ready,
        output wr_valid, wr_addr, wr_data, busy, err_range, err_timeout, err_overrun
    );

    modport slave (
        output rx_valid, rx_data, wr_ready,
        input  wr_valid, wr_addr, wr_data, busy, err_range, err_timeout, err_overrun
    );

endinterface

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter: cleared on load or when disabled, flags the last
// allowed idle cycle combinationally.
module uart_gap_timer #(
    parameter int unsigned TIMEOUT = 4340
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count_q;

    assign expired_c = enable && (count_q == CNT_W'(TIMEOUT - 1));

    // Saturates at terminal count; the owning FSM leaves the counting states then.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (clear || !enable) begin
            count_q <= '0;
        end else if (!expired_c) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_text_cmd_decoder.sv
// Turns (column, row, char) UART byte triples into text-buffer cell writes.
// Optional UART_TEXT_CLEAR_EN: byte 8'hFF in IDLE blanks the whole buffer.
import vga_text_pkg::*;

module uart_text_cmd_decoder #(
    parameter int unsigned COLS    = DEF_COLS,
    parameter int unsigned ROWS    = DEF_ROWS,
    parameter int unsigned CHAR_W  = 8,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned TIMEOUT = 4340
) (
    input  logic                     clk,
    input  logic                     resetn,
    uart_text_cmd_decoder_if.master  bus
);

`ifdef UART_TEXT_CLEAR_EN
    localparam int unsigned CELLS = COLS * ROWS;
`endif

    state_t            state_q, state_d;
    logic [7:0]        col_q, col_d;
    logic [7:0]        row_q, row_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [CHAR_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              err_range_q, err_range_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_overrun_q, err_overrun_d;

    logic timer_en_c;
    logic timeout_c;
    logic in_range_c;

    assign timer_en_c = (state_q == ST_GET_ROW) || (state_q == ST_GET_CHAR);
    assign in_range_c = (32'(col_q) < COLS) && (32'(row_q) < ROWS);

    uart_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (bus.rx_valid),
        .enable    (timer_en_c),
        .expired_c (timeout_c)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            col_q         <= '0;
            row_q         <= '0;
            wr_valid_q    <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            err_range_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            wr_valid_q    <= wr_valid_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= busy_d;
            err_range_q   <= err_range_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    // Next-state and next-output logic; a received byte always beats the gap timeout.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        wr_valid_d    = wr_valid_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        err_range_d   = 1'b0;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid) begin
`ifdef UART_TEXT_CLEAR_EN
                    if (bus.rx_data == CMD_CLEAR) begin
                        state_d    = ST_CLEAR;
                        wr_valid_d = 1'b1;
                        wr_addr_d  = '0;
                        wr_data_d  = CHAR_W'(ASCII_SPACE);
                    end else begin
                        col_d   = bus.rx_data;
                        state_d = ST_GET_ROW;
                    end
`else
                    col_d   = bus.rx_data;
                    state_d = ST_GET_ROW;
`endif
                end
            end

            ST_GET_ROW: begin
                if (bus.rx_valid) begin
                    row_d   = bus.rx_data;
                    state_d = ST_GET_CHAR;
                end else if (timeout_c) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end

            ST_GET_CHAR: begin
                if (bus.rx_valid) begin
                    if (in_range_c) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = ADDR_W'(cell_addr(32'(row_q), 32'(col_q), COLS));
                        wr_data_d  = CHAR_W'(bus.rx_data);
                        state_d    = ST_WRITE;
                    end else begin
                        err_range_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else if (timeout_c) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end

            // A byte arriving on the handshake cycle starts the next command.
            ST_WRITE: begin
                if (bus.wr_ready) begin
                    wr_valid_d = 1'b0;
                    if (bus.rx_valid) begin
                        col_d   = bus.rx_data;
                        state_d = ST_GET_ROW;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (bus.rx_valid) begin
                    err_overrun_d = 1'b1;
                end
            end

`ifdef UART_TEXT_CLEAR_EN
            // wr_addr doubles as the sweep counter.
            ST_CLEAR: begin
                if (bus.rx_valid) begin
                    err_overrun_d = 1'b1;
                end
                if (bus.wr_ready) begin
                    if (wr_addr_q == ADDR_W'(CELLS - 1)) begin
                        wr_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.wr_valid    = wr_valid_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.busy        = busy_q;
    assign bus.err_range   = err_range_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_text_cmd_decoder.sv
// Scoreboard bench for uart_text_cmd_decoder: a command-level reference model
// predicts writes and error pulses; a negedge monitor compares them.
module tb_uart_text_cmd_decoder;

    localparam int unsigned COLS    = 80;
    localparam int unsigned ROWS    = 30;
    localparam int unsigned CHAR_W  = 8;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned TIMEOUT = 4340;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    uart_text_cmd_decoder_if #(.ADDR_W(ADDR_W), .CHAR_W(CHAR_W)) bus ();

    uart_text_cmd_decoder #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .CHAR_W  (CHAR_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [CHAR_W-1:0] data;
    } wr_t;

    wr_t exp_wr[$];
    int  checks = 0;
    int  errors = 0;
    bit  started = 0;

    // Reference model: bytes of the command in progress, pending-write flag,
    // idle cycles since the last byte, and per-cycle expected error pulses.
    int m_buf[$];
    int m_gap = 0;
    bit m_pend = 0;
    int m_clr_left = 0;
    bit m_rst = 0, m_er = 0, m_et = 0, m_eo = 0;

    function automatic void model_step(input bit v, input logic [7:0] d,
                                       input bit r, input bit rn);
        wr_t w;
        int  col, row;
        m_er = 0; m_et = 0; m_eo = 0; m_rst = 0;
        if (!rn) begin
            m_buf.delete(); m_gap = 0; m_pend = 0; m_clr_left = 0;
            exp_wr.delete(); m_rst = 1;
            return;
        end
        if (m_pend) begin
            if (m_clr_left > 0) begin
                if (v) m_eo = 1;
                if (r) begin
                    m_clr_left--;
                    m_pend = (m_clr_left > 0);
                end
            end else if (r) begin
                m_pend = 0;
                if (v) begin
                    m_buf.push_back(int'(d));
                    m_gap = 0;
                end
            end else if (v) begin
                m_eo = 1;
            end
            return;
        end
        if (v) begin
            m_gap = 0;
`ifdef UART_TEXT_CLEAR_EN
            if (m_buf.size() == 0 && d == 8'hFF) begin
                for (int a = 0; a < int'(COLS * ROWS); a++) begin
                    w.addr = ADDR_W'(a);
                    w.data = CHAR_W'(8'h20);
                    exp_wr.push_back(w);
                end
                m_clr_left = COLS * ROWS;
                m_pend = 1;
                return;
            end
`endif
            m_buf.push_back(int'(d));
            if (m_buf.size() == 3) begin
                col = m_buf[0];
                row = m_buf[1];
                if (col < int'(COLS) && row < int'(ROWS)) begin
                    w.addr = ADDR_W'(row * int'(COLS) + col);
                    w.data = CHAR_W'(m_buf[2]);
                    exp_wr.push_back(w);
                    m_pend = 1;
                end else begin
                    m_er = 1;
                end
                m_buf.delete();
            end
        end else if (m_buf.size() > 0) begin
            if (m_gap == int'(TIMEOUT) - 1) begin
                m_et = 1;
                m_buf.delete();
                m_gap = 0;
            end else begin
                m_gap++;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample mid-cycle; wr_ready seen here is the value for the next edge.
    always @(negedge clk) begin
        if (started) begin
            chk("busy", 32'(bus.busy), 32'(m_pend || (m_buf.size() > 0)));
            chk("wr_valid", 32'(bus.wr_valid), 32'(m_pend));
            chk("err_range", 32'(bus.err_range), 32'(m_er));
            chk("err_timeout", 32'(bus.err_timeout), 32'(m_et));
            chk("err_overrun", 32'(bus.err_overrun), 32'(m_eo));
            if (m_rst) begin
                chk("rst_addr", 32'(bus.wr_addr), 32'd0);
                chk("rst_data", 32'(bus.wr_data), 32'd0);
            end
            if (bus.wr_valid === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %0d expected none",
                             bus.wr_addr, bus.wr_data);
                end else begin
                    chk("wr_addr", 32'(bus.wr_addr), 32'(exp_wr[0].addr));
                    chk("wr_data", 32'(bus.wr_data), 32'(exp_wr[0].data));
                    if (bus.wr_ready === 1'b1) void'(exp_wr.pop_front());
                end
            end
        end
    end

    task automatic tick(input bit v, input logic [7:0] d, input bit r, input bit rn);
        bus.rx_valid = v;
        bus.rx_data  = d;
        bus.wr_ready = r;
        resetn       = rn;
        @(posedge clk);
        model_step(v, d, r, rn);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        tick(1'b1, d, 1'b1, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'd0, 1'b1, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int long_gaps = 0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        bus.wr_ready = 1'b1;
        resetn       = 1'b0;
        @(posedge clk);
        #1;
        tick(1'b0, 8'd0, 1'b1, 1'b0);
        started = 1;
        tick(1'b0, 8'd0, 1'b1, 1'b0);
        idle(2);

        // Basic write, then in/out-of-range boundary columns.
        send(8'd17); send(8'd29); send(8'd50); idle(3);
        send(8'd79); send(8'd0); send(8'd57); idle(3);
        send(8'd80); send(8'd0); send(8'd65); idle(3);
        send(8'd0); send(8'd30); send(8'd65); idle(3);

        // Byte on the last allowed gap cycle survives; one more idle cycle times out.
        send(8'd17); idle(TIMEOUT - 1); send(8'd29); send(8'd50); idle(3);
        send(8'd17); idle(TIMEOUT); idle(2);
        send(8'd5); send(8'd1); send(8'd120); idle(3);

        // Backpressure with an overrun byte, then release.
        send(8'd1); send(8'd1); send(8'd66);
        for (int i = 0; i < 20; i++) tick(i == 10, 8'd7, 1'b0, 1'b1);
        idle(3);

        // Handshake cycle carrying the next column byte.
        send(8'd2); send(8'd2); send(8'd67);
        tick(1'b0, 8'd0, 1'b0, 1'b1);
        tick(1'b1, 8'd4, 1'b1, 1'b1);
        send(8'd4); send(8'd68); idle(3);

        // Reset mid-command.
        send(8'd17); send(8'd29);
        tick(1'b0, 8'd0, 1'b1, 1'b0);
        send(8'd3); send(8'd2); send(8'd65); idle(3);

        // 0xFF: full clear when enabled, ordinary out-of-range column otherwise.
`ifdef UART_TEXT_CLEAR_EN
        send(8'hFF);
        idle(COLS * ROWS + 5);
`else
        send(8'hFF); send(8'd0); send(8'd65); idle(3);
`endif

        // Random traffic with random backpressure and a few boundary-length gaps.
        for (int i = 0; i < 3000; i++) begin
            if (long_gaps < 3 && ($urandom % 400) == 0) begin
                long_gaps++;
                idle(int'(TIMEOUT) - 2 + int'($urandom_range(0, 2)));
            end
            tick(($urandom % 4) == 0, 8'($urandom_range(0, 99)),
                 ($urandom % 10) < 7, 1'b1);
        end

        idle(10);
        chk("drain_queue", 32'(exp_wr.size()), 32'd0);
        chk("drain_pend", 32'(m_pend), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
